// File: rtl/layer_stream_pkg.sv
// Shared types and width helpers for the layer streaming interface.
// Pointer/counter widths are derived here so every block sizes them the same way.
package layer_stream_pkg;

    localparam int T_DEF = 16;
    localparam int M_DEF = 8;

    typedef logic signed [T_DEF-1:0] word_t;

    // Index width for 0..n-1 (at least one bit).
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Count width for 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stream_buf_mem.sv
// Word storage for layer_input_tx: one synchronous write port, one combinational read port.
// Contents are never reset; the control logic only reads words it has written.
module stream_buf_mem #(
    parameter int T   = 16,
    parameter int CAP = 16,
    parameter int AW  = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [T-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic signed [T-1:0] rdata
);

    logic signed [T-1:0] mem [CAP];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/layer_input_tx.sv
// Loader-to-layer transmit buffer: words become visible downstream only once a full
// M-word vector is stored, so each vector leaves as an uninterrupted burst.
module layer_input_tx
    import layer_stream_pkg::*;
#(
    parameter int T     = T_DEF,
    parameter int M     = M_DEF,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic signed [T-1:0] wr_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [T-1:0] data_out,
    output logic                m_last,
    output logic                vec_done
);

    localparam int CAP = DEPTH * M;
    localparam int PW  = ptr_w(CAP);
    localparam int CW  = cnt_w(CAP);
    localparam int EW  = ptr_w(M);

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [CW-1:0] used, avail, used_nx, avail_nx;
    logic [EW-1:0] pending, elem, pending_nx, elem_nx;
    logic          wr_fire, out_fire, load, commit;
    logic signed [T-1:0] rd_word;

    stream_buf_mem #(
        .T   (T),
        .CAP (CAP),
        .AW  (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    // used counts the output register too, so ready depends on registers only
    assign wr_ready = (used < CW'(CAP));

    always_comb begin
        wr_fire    = wr_valid && wr_ready;
        out_fire   = m_valid && m_ready;
        load       = (!m_valid || m_ready) && (avail != '0);
        commit     = wr_fire && (pending == EW'(M - 1));
        wr_ptr_nx  = wr_ptr;
        rd_ptr_nx  = rd_ptr;
        pending_nx = pending;
        elem_nx    = elem;
        if (wr_fire) begin
            wr_ptr_nx  = (wr_ptr == PW'(CAP - 1)) ? '0 : wr_ptr + PW'(1);
            pending_nx = commit ? '0 : pending + EW'(1);
        end
        if (load) begin
            rd_ptr_nx = (rd_ptr == PW'(CAP - 1)) ? '0 : rd_ptr + PW'(1);
            elem_nx   = (elem == EW'(M - 1)) ? '0 : elem + EW'(1);
        end
        // a vector committed this cycle is loadable only from the next cycle
        avail_nx = avail - CW'(load) + (commit ? CW'(M) : '0);
        used_nx  = used + CW'(wr_fire) - CW'(out_fire);
    end

    // output register stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used     <= '0;
            avail    <= '0;
            pending  <= '0;
            elem     <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            vec_done <= 1'b0;
            data_out <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            used     <= used_nx;
            avail    <= avail_nx;
            pending  <= pending_nx;
            elem     <= elem_nx;
            vec_done <= out_fire && m_last;
            if (load) begin
                data_out <= rd_word;
                m_valid  <= 1'b1;
                m_last   <= (elem == EW'(M - 1));
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer_input_tx.sv
// Bench for layer_input_tx: static-state table plus multi-cycle sequences, all outputs
// checked against a scoreboard of committed vectors.
module tb_layer_input_tx;
    import layer_stream_pkg::*;

    localparam int M   = 8;
    localparam int CAP = 16;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  wr_valid = 1'b0;
    logic  wr_ready;
    word_t wr_data = '0;
    logic  m_valid;
    logic  m_ready = 1'b0;
    word_t data_out;
    logic  m_last;
    logic  vec_done;

    int nchk = 0;
    int nfail = 0;

    word_t pend_q[$];
    word_t exp_q[$];
    int    mused = 0;
    int    oi = 0;
    logic  exp_vd = 1'b0;
    int    vd_cnt = 0;

    typedef struct {
        int    nwords;
        word_t base;
        logic  exp_mv;
        logic  exp_wr;
        word_t exp_do;
    } vec_t;
    vec_t tbl[6];

    layer_input_tx #(.T(16), .M(M), .DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .data_out (data_out),
        .m_last   (m_last),
        .vec_done (vec_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: writes feed the model, output handshakes pop it.
    always @(negedge clk) begin
        if (!reset) begin
            pend_q.delete();
            exp_q.delete();
            mused  = 0;
            oi     = 0;
            exp_vd = 1'b0;
        end else begin
            chk("wr_ready", wr_ready, (mused < CAP) ? 1 : 0);
            chk("vec_done", vec_done, exp_vd);
            if (vec_done) vd_cnt++;
            exp_vd = 1'b0;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_m_valid", m_valid, 0);
                end else begin
                    chk("data_out", data_out, exp_q[0]);
                    chk("m_last", m_last, (oi == M - 1) ? 1 : 0);
                end
                if (m_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    exp_vd = (oi == M - 1);
                    oi     = (oi == M - 1) ? 0 : oi + 1;
                    mused--;
                end
            end
            if (wr_valid && wr_ready) begin
                pend_q.push_back(wr_data);
                mused++;
                if (pend_q.size() == M) begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                    pend_q.delete();
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; wr_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Called just after a posedge; returns just after the edge that took the word.
    task automatic wr_word(input word_t v);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = v;
        @(negedge clk);
        while (!wr_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!wr_ready) begin
            nchk++; nfail++;
            $display("FAIL wr_timeout: got wr_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        m_ready = 1'b1;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !m_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk(nm, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int vd0;
        int k;
        tbl[0] = '{0,  16'sd0,   1'b0, 1'b1, 16'sd0};
        tbl[1] = '{5,  16'sd10,  1'b0, 1'b1, 16'sd0};
        tbl[2] = '{7,  -16'sd3,  1'b0, 1'b1, 16'sd0};
        tbl[3] = '{8,  16'sd20,  1'b1, 1'b1, 16'sd20};
        tbl[4] = '{12, -16'sd50, 1'b1, 1'b1, -16'sd50};
        tbl[5] = '{16, 16'sd70,  1'b1, 1'b0, 16'sd70};

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Static state after loading n words with the layer stalled
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < tbl[r].nwords; i++) wr_word(tbl[r].base + word_t'(i));
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_m_valid", r), m_valid, tbl[r].exp_mv);
            chk($sformatf("tbl%0d_wr_ready", r), wr_ready, tbl[r].exp_wr);
            chk($sformatf("tbl%0d_data_out", r), data_out, tbl[r].exp_do);
            chk($sformatf("tbl%0d_m_last", r), m_last, 0);
        end

        // Basic burst 1..8 with the layer always ready
        do_reset();
        m_ready = 1'b1;
        vd0 = vd_cnt;
        for (int i = 1; i <= 8; i++) wr_word(word_t'(i));
        @(negedge clk);
        chk("t1_lat_edge_k", m_valid, 0);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            chk($sformatf("t1_burst_%0d", i), m_valid, 1);
        end
        @(negedge clk);
        chk("t1_after_burst", m_valid, 0);
        @(negedge clk);
        chk("t1_vec_done_count", vd_cnt - vd0, 1);
        @(posedge clk); #1;

        // Partial vector stays invisible until completed
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) wr_word(word_t'(30 + i));
        repeat (20) @(negedge clk);
        chk("t2_partial_m_valid", m_valid, 0);
        @(posedge clk); #1;
        wr_word(word_t'(37));
        @(negedge clk);
        chk("t2_lat_edge_k", m_valid, 0);
        @(negedge clk);
        chk("t2_burst_start", m_valid, 1);
        wait_drain("t2_drain");

        // Full buffer back-pressure
        do_reset();
        for (int i = 0; i < 16; i++) wr_word(word_t'(200 + i));
        @(negedge clk);
        chk("t3_full_wr_ready", wr_ready, 0);
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = word_t'(216);
        repeat (3) begin
            @(negedge clk);
            chk("t3_blocked_wr_ready", wr_ready, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("t3_slot_freed", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("t3_full_again", wr_ready, 0);
        @(posedge clk); #1;
        wait_drain("t3_drain");

        // Stall pattern 1,0,0,1 across a vector boundary
        do_reset();
        for (int i = 0; i < 16; i++) wr_word(word_t'(300 + i));
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            m_ready = (k % 4 == 0 || k % 4 == 3);
            k++;
            @(posedge clk); #1;
        end
        chk("t4_stall_left", exp_q.size(), 0);
        wait_drain("t4_drain");

        // Concurrent full-rate write and read, values -40..-1
        do_reset();
        m_ready = 1'b1;
        for (int i = -40; i < 0; i++) wr_word(word_t'(i));
        wait_drain("t5_drain");

        // Reset mid-burst after element 3, then a fresh vector
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) wr_word(word_t'(50 + i));
        k = 0;
        while (oi != 4 && k < 100) begin
            k++;
            @(posedge clk); #1;
        end
        chk("t6_reached_elem3", oi, 4);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_m_valid_after_reset", m_valid, 0);
        chk("t6_data_out_after_reset", data_out, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) wr_word(word_t'(100 + i));
        wait_drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
